// File: rtl/uart_tx_arbiter_if.sv
// Bundle of client byte streams, the TX FIFO write port and arbiter status.
// The master side is the environment (clients plus FIFO); the slave side is the arbiter.
interface uart_tx_arbiter_if #(
  parameter int NumReq     = 4,
  parameter int DataLength = 8
);
  localparam int GrantWidth = $clog2(NumReq) + 1;

  logic [NumReq-1:0]            req_valid;
  logic [NumReq*DataLength-1:0] req_data;
  logic [NumReq-1:0]            req_last;
  logic [NumReq-1:0]            req_ready;
  logic [DataLength-1:0]        fifo_data;
  logic                         fifo_wr_en;
  logic                         fifo_full;
  logic [GrantWidth-1:0]        grant_id;
  logic                         busy;

  modport master (
    output req_valid, req_data, req_last, fifo_full,
    input  req_ready, fifo_data, fifo_wr_en, grant_id, busy
  );

  modport slave (
    input  req_valid, req_data, req_last, fifo_full,
    output req_ready, fifo_data, fifo_wr_en, grant_id, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter that funnels NumReq byte streams into one
// UART TX FIFO. A grant lasts until the client's last byte or MaxBurst bytes.
// grant_id reports the owner as client index + 1, so 0 means no owner.
// Optional feature: define UART_ARB_FRAME_HDR_EN to emit a header byte
// {1'b1, client index} ahead of every grant, including burst resumes.
module uart_tx_arbiter #(
  parameter int NumReq     = 4,
  parameter int DataLength = 8,
  parameter int MaxBurst   = 16
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  uart_tx_arbiter_if.slave bus
);
  localparam int GrantWidth = $clog2(NumReq) + 1;
  localparam int IdxWidth   = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int CntWidth   = (MaxBurst > 0) ? $clog2(MaxBurst + 1) : 1;
  localparam logic [CntWidth:0] BurstLimit = (CntWidth + 1)'(MaxBurst);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    HDR  = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [IdxWidth-1:0]   grant;
  logic [IdxWidth-1:0]   last_grant;
  logic [CntWidth-1:0]   byte_cnt;
  logic [CntWidth:0]     cnt_next;
  logic                  pick_valid;
  logic [IdxWidth-1:0]   pick_idx;
  logic                  grant_valid;
  logic                  grant_last;
  logic [DataLength-1:0] grant_data;
  logic                  xfer_fire;
  logic                  release_now;

  assign grant_valid = bus.req_valid[grant];
  assign grant_last  = bus.req_last[grant];
  assign grant_data  = bus.req_data[grant*DataLength +: DataLength];

  // Round-robin search: first valid client starting just after the last owner.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int i = 1; i <= NumReq; i++) begin
      int idx;
      idx = (int'(last_grant) + i) % NumReq;
      if (!pick_valid && bus.req_valid[idx]) begin
        pick_valid = 1'b1;
        pick_idx   = IdxWidth'(idx);
      end
    end
  end

  // Next state plus all FIFO/handshake outputs, combinational from the current grant.
  always_comb begin
    state_next     = state;
    release_now    = 1'b0;
    xfer_fire      = 1'b0;
    cnt_next       = {1'b0, byte_cnt} + (CntWidth + 1)'(1);
    bus.req_ready  = '0;
    bus.fifo_data  = '0;
    bus.fifo_wr_en = 1'b0;
    bus.busy       = 1'b0;
    bus.grant_id   = '0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
`ifdef UART_ARB_FRAME_HDR_EN
          state_next = HDR;
`else
          state_next = XFER;
`endif
        end
      end
`ifdef UART_ARB_FRAME_HDR_EN
      HDR: begin
        bus.busy       = 1'b1;
        bus.grant_id   = GrantWidth'(grant) + GrantWidth'(1);
        bus.fifo_wr_en = !bus.fifo_full;
        bus.fifo_data  = {1'b1, (DataLength - 1)'(grant)};
        if (!bus.fifo_full) begin
          state_next = XFER;
        end
      end
`endif
      XFER: begin
        bus.busy              = 1'b1;
        bus.grant_id          = GrantWidth'(grant) + GrantWidth'(1);
        bus.req_ready[grant]  = !bus.fifo_full;
        bus.fifo_data         = grant_data;
        xfer_fire             = grant_valid && !bus.fifo_full;
        bus.fifo_wr_en        = xfer_fire;
        if (xfer_fire && (grant_last || (MaxBurst != 0 && cnt_next == BurstLimit))) begin
          release_now = 1'b1;
          state_next  = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Grant owner, round-robin pointer and burst counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      grant      <= '0;
      last_grant <= IdxWidth'(NumReq - 1);
      byte_cnt   <= '0;
    end else begin
      if (state == IDLE && pick_valid) begin
        grant <= pick_idx;
      end
      if (release_now) begin
        last_grant <= grant;
        byte_cnt   <= '0;
      end else if (xfer_fire && MaxBurst != 0) begin
        byte_cnt <= cnt_next[CntWidth-1:0];
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: directed client packets, expected FIFO
// bytes queued in hand-derived order, a monitor comparing every FIFO write.
module tb_uart_tx_arbiter;
  localparam int NumReq     = 4;
  localparam int DataLength = 8;
  localparam int MaxBurst   = 4;
`ifdef UART_ARB_FRAME_HDR_EN
  localparam bit HdrEn = 1'b1;
`else
  localparam bit HdrEn = 1'b0;
`endif

  logic clock = 1'b0;
  logic resetN;

  always #5 clock = ~clock;

  uart_tx_arbiter_if #(.NumReq(NumReq), .DataLength(DataLength)) bus ();

  uart_tx_arbiter #(
    .NumReq    (NumReq),
    .DataLength(DataLength),
    .MaxBurst  (MaxBurst)
  ) dut (
    .i_clk  (clock),
    .i_rst_n(resetN),
    .bus    (bus)
  );

  int testsRun    = 0;
  int testsFailed = 0;

  logic [7:0] expQ[$];
  logic [8:0] clientMem[NumReq][64];
  int         head[NumReq];
  int         tail[NumReq];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic refreshInputs();
    logic [NumReq-1:0]            v;
    logic [NumReq-1:0]            l;
    logic [NumReq*DataLength-1:0] d;
    v = '0;
    l = '0;
    d = '0;
    for (int k = 0; k < NumReq; k++) begin
      if (head[k] < tail[k]) begin
        v[k] = 1'b1;
        l[k] = clientMem[k][head[k]][8];
        d[k*DataLength +: DataLength] = clientMem[k][head[k]][7:0];
      end
    end
    bus.req_valid = v;
    bus.req_last  = l;
    bus.req_data  = d;
  endtask

  task automatic applyStimulus(input int client, input logic [7:0] data, input bit last);
    clientMem[client][tail[client]] = {last, data};
    tail[client]++;
    refreshInputs();
  endtask

  task automatic expectByte(input logic [7:0] b);
    expQ.push_back(b);
  endtask

  task automatic expectHeader(input int client);
    if (HdrEn) expQ.push_back({1'b1, 7'(client)});
  endtask

  function automatic bit clientsEmpty();
    bit e;
    e = 1'b1;
    for (int k = 0; k < NumReq; k++) if (head[k] != tail[k]) e = 1'b0;
    return e;
  endfunction

  task automatic waitDrain(input string name, input int maxCycles);
    int n;
    n = 0;
    while (n < maxCycles && !(expQ.size() == 0 && clientsEmpty() && bus.busy === 1'b0)) begin
      @(negedge clock);
      n++;
    end
    checkOutput(name, {31'd0, n < maxCycles}, 32'd1);
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    resetN = 1'b0;
    bus.fifo_full = 1'b0;
    for (int k = 0; k < NumReq; k++) begin
      head[k] = 0;
      tail[k] = 0;
    end
    refreshInputs();
    expQ.delete();
    repeat (2) @(negedge clock);
    checkOutput("resetOutputs",
                {15'd0, bus.fifo_data, bus.fifo_wr_en, bus.req_ready, bus.grant_id, bus.busy}, 32'd0);
    @(posedge clock);
    #1;
    resetN = 1'b1;
  endtask

  // Monitor: every FIFO write must match the head of the expected queue.
  initial begin
    forever begin : monitorLoop
      logic [7:0] e;
      @(negedge clock);
      if (bus.fifo_wr_en === 1'b1) begin
        if (expQ.size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpectedWrite: got 0x%0h, expected no write", bus.fifo_data);
        end else begin
          e = expQ.pop_front();
          checkOutput("fifoData", {24'd0, bus.fifo_data}, {24'd0, e});
        end
      end
    end
  end

  // Client model: a byte accepted on a cycle is retired just after that edge.
  initial begin
    forever begin : driverLoop
      logic [NumReq-1:0] took;
      @(negedge clock);
      took = bus.req_valid & bus.req_ready;
      @(posedge clock);
      #1;
      for (int k = 0; k < NumReq; k++) if (took[k] === 1'b1) head[k]++;
      refreshInputs();
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int n;
    bit found;
    resetN = 1'b0;
    bus.fifo_full = 1'b0;
    for (int k = 0; k < NumReq; k++) begin
      head[k] = 0;
      tail[k] = 0;
    end
    refreshInputs();

    // Reset, then idle with everything quiet
    doReset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      checkOutput("idleOutputs",
                  {15'd0, bus.fifo_data, bus.fifo_wr_en, bus.req_ready, bus.grant_id, bus.busy}, 32'd0);
    end
    @(posedge clock);
    #1;

    // Single 3-byte packet from client 0, cycle-exact
    applyStimulus(0, 8'h11, 1'b0);
    applyStimulus(0, 8'h22, 1'b0);
    applyStimulus(0, 8'h33, 1'b1);
    expectHeader(0);
    expectByte(8'h11);
    expectByte(8'h22);
    expectByte(8'h33);
    @(negedge clock);
    checkOutput("arbCycleNoWrite", {30'd0, bus.fifo_wr_en, bus.busy}, 32'd0);
    if (HdrEn) begin
      @(negedge clock);
      checkOutput("hdrCycle", {30'd0, bus.fifo_wr_en, bus.busy}, 32'd3);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      checkOutput("xferCycle", {23'd0, bus.fifo_wr_en, bus.busy, bus.grant_id, bus.req_ready},
                  {23'd0, 1'b1, 1'b1, 3'd1, 4'b0001});
    end
    @(negedge clock);
    checkOutput("releaseIdle", {27'd0, bus.busy, bus.grant_id, bus.fifo_wr_en}, 32'd0);
    @(posedge clock);
    #1;

    // Round-robin order
    doReset();
    applyStimulus(0, 8'hA0, 1'b0);
    applyStimulus(0, 8'hA1, 1'b1);
    applyStimulus(2, 8'hC0, 1'b1);
    expectHeader(0); expectByte(8'hA0); expectByte(8'hA1);
    expectHeader(2); expectByte(8'hC0);
    waitDrain("rrFirstDrain", 40);
    applyStimulus(0, 8'hB0, 1'b1);
    applyStimulus(1, 8'hB1, 1'b1);
    expectHeader(0); expectByte(8'hB0);
    expectHeader(1); expectByte(8'hB1);
    waitDrain("rrWrapDrain", 40);
    applyStimulus(3, 8'hD3, 1'b1);
    applyStimulus(1, 8'hD1, 1'b1);
    expectHeader(3); expectByte(8'hD3);
    expectHeader(1); expectByte(8'hD1);
    waitDrain("rrSkipDrain", 40);

    // FIFO full for 4 cycles mid-packet
    applyStimulus(1, 8'h41, 1'b0);
    applyStimulus(1, 8'h42, 1'b0);
    applyStimulus(1, 8'h43, 1'b1);
    expectHeader(1); expectByte(8'h41); expectByte(8'h42); expectByte(8'h43);
    found = 1'b0;
    n = 0;
    while (!found && n < 20) begin
      @(negedge clock);
      n++;
      if (bus.fifo_wr_en === 1'b1 && bus.fifo_data === 8'h41) found = 1'b1;
    end
    checkOutput("fullSawFirst", {31'd0, found}, 32'd1);
    @(posedge clock);
    #1;
    bus.fifo_full = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      checkOutput("fullStall", {23'd0, bus.req_ready, bus.fifo_wr_en, bus.busy, bus.grant_id},
                  {23'd0, 4'b0000, 1'b0, 1'b1, 3'd2});
    end
    @(posedge clock);
    #1;
    bus.fifo_full = 1'b0;
    waitDrain("fullDrain", 40);

    // MaxBurst release and mid-packet resume
    doReset();
    for (int b = 0; b < 6; b++) applyStimulus(1, 8'h60 + 8'(b), b == 5);
    @(posedge clock);
    #1;
    applyStimulus(0, 8'h70, 1'b0);
    applyStimulus(0, 8'h71, 1'b1);
    expectHeader(1);
    for (int b = 0; b < 4; b++) expectByte(8'h60 + 8'(b));
    expectHeader(0); expectByte(8'h70); expectByte(8'h71);
    expectHeader(1); expectByte(8'h64); expectByte(8'h65);
    waitDrain("burstDrain", 60);

    // Client 3 single byte (header 0x83 when framing is enabled)
    applyStimulus(3, 8'h5A, 1'b1);
    expectHeader(3); expectByte(8'h5A);
    waitDrain("client3Drain", 30);

    // Owner drops valid mid-packet; another client must wait
    applyStimulus(2, 8'h90, 1'b0);
    expectHeader(2); expectByte(8'h90);
    repeat (3) @(posedge clock);
    #1;
    applyStimulus(0, 8'hA5, 1'b1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      checkOutput("dropHold", {27'd0, bus.busy, bus.grant_id, bus.fifo_wr_en},
                  {27'd0, 1'b1, 3'd3, 1'b0});
    end
    @(posedge clock);
    #1;
    applyStimulus(2, 8'h91, 1'b1);
    expectByte(8'h91);
    expectHeader(0); expectByte(8'hA5);
    waitDrain("dropDrain", 40);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
